regfile: RTL and testbench
==========================

Name: regfile

Overview:
Two-read/one-write general-purpose register file for the single-cycle datapath, sitting directly upstream of the ALU.
- Driven by the rs/rt/rd fields and the write-back bus.
- Produces busa/busb, which feed the ALU operand inputs.
- Contents are cleared by a post-reset sweep state machine, not by resetting every flop.
- A read bypass lets same-cycle write data appear on the read ports.

Parameters:
- DW, 32, data width of each register and of all buses.
- AW, 5, register address width.
- NREG, 32, number of registers; always 2**AW.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- ra  input  AW  read address for port A (rs).
- rb  input  AW  read address for port B (rt).
- rw  input  AW  write address (rd/rt from write-back).
- busw  input  DW  write data.
- regwr  input  1  write enable.
- busa  output  DW  read data for port A, to the ALU.
- busb  output  DW  read data for port B, to the ALU.
- ready  output  1  high once the init sweep is complete.

Behaviour:
- Reset value of every output:
  - ready = 0.
  - busa = busb = 0.
  - Internal: state = INIT, sweep pointer ptr = 0.
  - Register array storage is not reset; the sweep clears it.
- States:
  - INIT: clearing storage.
  - RUN: normal operation.
- INIT, on each rising clk:
  - mem[ptr] <= 0.
  - ptr <= ptr + 1, width AW, wraps.
  - When ptr == NREG-1 is written: state <= RUN and ready <= 1, both registered.
- Sweep timing:
  - Exactly NREG edges after rst deasserts, i.e. 32 edges by default.
  - ready rises right after the 32nd edge.
- During INIT:
  - regwr is ignored; no user write lands.
  - busa = busb = 0 regardless of address.
- RUN, rising clk:
  - If regwr && rw != 0, then mem[rw] <= busw.
  - Otherwise storage holds.
  - RUN is terminal until the next rst.
- Reads in RUN are combinational, with zero latency:
  - busa = 0 if ra == 0.
  - Otherwise busa = busw if bypass is enabled and regwr && rw == ra.
  - Otherwise busa = mem[ra].
  - busb follows the same rule using rb.
- Register 0 is hardwired:
  - A write to rw = 0 is discarded.
  - Reads of address 0 always return 0, including when rw = 0 with regwr = 1 under bypass.
- Simultaneous events:
  - ra == rb == rw: both ports see the same value, the bypassed value if bypass is enabled.
  - A write and a read of the same register in the same cycle are legal.
- Reset mid-operation:
  - rst asserted at any time, including mid-sweep, immediately forces INIT, ptr = 0 and ready = 0.
  - The sweep restarts from register 0; partial writes are irrelevant.
- Width rules: no arithmetic on data; ptr increments modulo NREG.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-to-read bypass as described above. Same-cycle write data is visible on busa/busb before the edge.
- Undefined: no bypass. Reads return mem[] only, so the new value is visible the cycle after the write edge. The register-0 and INIT rules are unchanged.

Decomposition:
- Package regfile_pkg holds:
  - Constants DW, AW, NREG.
  - Enum state type {INIT, RUN}.
  - The typedef for register address and data words.
- Single module only. The sweep FSM is too small to justify a sub-module. Read-mux logic stays inline as two identical assign blocks, or one function declared in the package.

Test Plan:
- rst pulse, then release -> ready = 0 for 32 edges, then 1. Every register reads 0. A write with regwr = 1, rw = 5, busw = 32'hDEAD_BEEF issued at edge 10 is ignored; r5 still reads 0 after ready.
- RUN: write rw = 3, busw = 32'h0000_1234; next cycle ra = 3, rb = 3 -> busa = busb = 32'h0000_1234.
- RUN: regwr = 1, rw = 0, busw = 32'hFFFF_FFFF, ra = 0 -> busa = 0 in the same cycle and the next.
- REGFILE_BYPASS_EN defined: r7 holds 32'h11; same cycle regwr = 1, rw = 7, busw = 32'h22, ra = 7 -> busa = 32'h22 before the edge. Undefined -> busa = 32'h11 before the edge and 32'h22 after it.
- Mid-sweep reset: assert rst at sweep edge 15 -> ready stays 0. After release, exactly 32 more edges pass before ready = 1.
- Post-init operands: r1 = 32'h8000_F000, r2 = 32'h0003_C000; ra = 1, rb = 2 -> busa = 32'h8000_F000, busb = 32'h0003_C000, presented to the ALU.

Source files
------------

// File: rtl/regfile_pkg.sv
// ============================================================================
// regfile_pkg : shared constants, types and read-port mux for regfile
// Revision    : 1.0
// ============================================================================
`default_nettype none

package regfile_pkg;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NREG = 2 ** AW;

  typedef logic [AW-1:0] addr_t;
  typedef logic [DW-1:0] data_t;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Register 0 reads as zero even when it is the target of a bypassed write.
  function automatic data_t rd_port(
    input addr_t ra,
    input data_t mem_val,
    input addr_t rw,
    input logic  regwr,
    input data_t busw,
    input logic  bypass
  );
    data_t res;
    res = mem_val;
    if (ra == '0) begin
      res = '0;
    end else if (bypass && regwr && (rw == ra)) begin
      res = busw;
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/regfile.sv
// ============================================================================
// regfile : 2R/1W register file with post-reset clearing sweep.
//           Define REGFILE_BYPASS_EN for same-cycle write-to-read bypass.
// Revision : 1.0
// ============================================================================
`default_nettype none

module regfile
  import regfile_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] ra,
  input  logic [AW-1:0] rb,
  input  logic [AW-1:0] rw,
  input  logic [DW-1:0] busw,
  input  logic          regwr,
  output logic [DW-1:0] busa,
  output logic [DW-1:0] busb,
  output logic          ready
);

`ifdef REGFILE_BYPASS_EN
  localparam logic C_BYPASS = 1'b1;
`else
  localparam logic C_BYPASS = 1'b0;
`endif

  localparam addr_t C_LAST = addr_t'(NREG - 1);

  state_e state_q, state_d;
  addr_t  ptr_q, ptr_d;
  logic   ready_q, ready_d;

  data_t  mem [NREG];

  logic   we;
  addr_t  waddr;
  data_t  wdata;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ready_d = ready_q;
    we      = 1'b0;
    waddr   = rw;
    wdata   = busw;
    case (state_q)
      INIT: begin
        we    = 1'b1;
        waddr = ptr_q;
        wdata = '0;
        ptr_d = ptr_q + addr_t'(1);
        if (ptr_q == C_LAST) begin
          state_d = RUN;
          ready_d = 1'b1;
        end
      end
      RUN: begin
        we = regwr && (rw != '0);
      end
      default: begin
        state_d = INIT;
        ptr_d   = '0;
        ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= INIT;
      ptr_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ready_q <= ready_d;
    end
  end

  // Storage is deliberately not reset; the INIT sweep zeroes it.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign busa  = (state_q == RUN) ? rd_port(ra, mem[ra], rw, regwr, busw, C_BYPASS) : '0;
  assign busb  = (state_q == RUN) ? rd_port(rb, mem[rb], rw, regwr, busw, C_BYPASS) : '0;
  assign ready = ready_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile.sv
// ============================================================================
// tb_regfile : randomized self-checking bench for regfile against an array model.
// Revision   : 1.0
// ============================================================================
`default_nettype none

module tb_regfile;
  import regfile_pkg::*;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] ra, rb, rw;
  logic [DW-1:0] busw;
  logic          regwr;
  logic [DW-1:0] busa, busb;
  logic          ready;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] model [NREG];
  bit            model_ready = 1'b0;

  regfile dut (
    .clk   (clk),
    .rst   (rst),
    .ra    (ra),
    .rb    (rb),
    .rw    (rw),
    .busw  (busw),
    .regwr (regwr),
    .busa  (busa),
    .busb  (busb),
    .ready (ready)
  );

  always #5 clk = ~clk;

  // Architectural read result for the current input values.
  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    if (!model_ready)                       return '0;
    if (a == 0)                             return '0;
    if (BYP && regwr && (rw == a))          return busw;
    return model[a];
  endfunction

  // One clock edge; the model commits a RUN write at the edge.
  task automatic tick();
    @(posedge clk);
    if (model_ready && regwr && (rw != 0)) model[rw] = busw;
    #1;
  endtask

  task automatic idle();
    regwr = 1'b0; rw = '0; busw = '0; ra = '0; rb = '0;
  endtask

  task automatic sweep_and_check(input int write_edge);
    for (int e = 1; e <= NREG; e++) begin
      ra = AW'($urandom); rb = AW'($urandom);
      if (e == write_edge) begin
        regwr = 1'b1; rw = 5'd5; busw = 32'hDEAD_BEEF;
      end else begin
        regwr = 1'b0;
      end
      #2;
      total++;
      if (busa !== '0 || busb !== '0) begin
        bad++; $display("FAIL init_read edge=%0d: busa=%h busb=%h required 0", e, busa, busb);
      end
      tick();
      total++;
      if (ready !== (e == NREG)) begin
        bad++; $display("FAIL sweep_ready edge=%0d: ready=%b required %b", e, ready, (e == NREG));
      end
    end
    for (int i = 0; i < NREG; i++) model[i] = '0;
    model_ready = 1'b1;
    idle();
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (ready !== 1'b0 || busa !== '0 || busb !== '0) begin
      bad++; $display("FAIL reset_state: ready=%b busa=%h busb=%h required 0/0/0", ready, busa, busb);
    end
    rst = 1'b0;
    sweep_and_check(10);
  endtask

  task automatic test_all_zero();
    for (int i = 0; i < NREG; i += 2) begin
      ra = AW'(i); rb = AW'(i + 1);
      #2;
      total++;
      if (busa !== '0 || busb !== '0) begin
        bad++; $display("FAIL cleared r%0d/r%0d: busa=%h busb=%h required 0", i, i + 1, busa, busb);
      end
    end
    idle();
  endtask

  task automatic test_write_read();
    regwr = 1'b1; rw = 5'd3; busw = 32'h0000_1234;
    tick();
    idle();
    ra = 5'd3; rb = 5'd3;
    #2;
    total++;
    if (busa !== 32'h0000_1234 || busb !== 32'h0000_1234) begin
      bad++; $display("FAIL write_read: busa=%h busb=%h required 00001234", busa, busb);
    end
    tick();
  endtask

  task automatic test_r0();
    regwr = 1'b1; rw = '0; busw = 32'hFFFF_FFFF; ra = '0; rb = '0;
    #2;
    total++;
    if (busa !== '0 || busb !== '0) begin
      bad++; $display("FAIL r0_same: busa=%h busb=%h required 0", busa, busb);
    end
    tick();
    regwr = 1'b0;
    #2;
    total++;
    if (busa !== '0) begin
      bad++; $display("FAIL r0_next: busa=%h required 0", busa);
    end
    idle();
  endtask

  task automatic test_bypass();
    regwr = 1'b1; rw = 5'd7; busw = 32'h11;
    tick();
    busw = 32'h22; ra = 5'd7; rb = 5'd7;
    #2;
    total++;
    if (busa !== exp_rd(ra) || busa !== (BYP ? 32'h22 : 32'h11)) begin
      bad++; $display("FAIL bypass_before: busa=%h required %h", busa, (BYP ? 32'h22 : 32'h11));
    end
    tick();
    regwr = 1'b0;
    #2;
    total++;
    if (busa !== 32'h22 || busb !== 32'h22) begin
      bad++; $display("FAIL bypass_after: busa=%h busb=%h required 00000022", busa, busb);
    end
    idle();
  endtask

  task automatic test_operands();
    regwr = 1'b1; rw = 5'd1; busw = 32'h8000_F000;
    tick();
    rw = 5'd2; busw = 32'h0003_C000;
    tick();
    idle();
    ra = 5'd1; rb = 5'd2;
    #2;
    total++;
    if (busa !== 32'h8000_F000 || busb !== 32'h0003_C000) begin
      bad++; $display("FAIL operands: busa=%h busb=%h required 8000f000 0003c000", busa, busb);
    end
    idle();
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      regwr = ($urandom_range(0, 3) != 0);
      rw    = AW'($urandom_range(0, 7));
      busw  = $urandom;
      case ($urandom_range(0, 3))
        0:       begin ra = rw; rb = rw; end
        1:       begin ra = rw; rb = AW'($urandom_range(0, 7)); end
        default: begin ra = AW'($urandom_range(0, 7)); rb = AW'($urandom); end
      endcase
      #2;
      total++;
      if (busa !== exp_rd(ra) || busb !== exp_rd(rb)) begin
        bad++; $display("FAIL random n=%0d ra=%0d rb=%0d rw=%0d we=%b: busa=%h busb=%h required %h %h",
                        n, ra, rb, rw, regwr, busa, busb, exp_rd(ra), exp_rd(rb));
      end
      tick();
    end
    idle();
  endtask

  task automatic test_mid_sweep_reset();
    regwr = 1'b1; rw = 5'd9; busw = 32'hCAFE_0009;
    tick();
    idle();
    rst = 1'b1;
    model_ready = 1'b0;
    #2;
    total++;
    if (ready !== 1'b0 || busa !== '0) begin
      bad++; $display("FAIL async_reset: ready=%b busa=%h required 0", ready, busa);
    end
    tick();
    rst = 1'b0;
    for (int e = 1; e <= 15; e++) tick();
    total++;
    if (ready !== 1'b0) begin
      bad++; $display("FAIL mid_sweep_ready: ready=%b required 0", ready);
    end
    rst = 1'b1;
    #2;
    tick();
    total++;
    if (ready !== 1'b0) begin
      bad++; $display("FAIL mid_sweep_reset: ready=%b required 0", ready);
    end
    rst = 1'b0;
    sweep_and_check(20);
    ra = 5'd9; rb = 5'd5;
    #2;
    total++;
    if (busa !== '0 || busb !== '0) begin
      bad++; $display("FAIL resweep_clear: busa=%h busb=%h required 0", busa, busb);
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_all_zero();
    test_write_read();
    test_r0();
    test_bypass();
    test_operands();
    test_random();
    test_mid_sweep_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
